// File: rtl/axi4_lite_byte_port_pkg.sv
// ============================================================================
// Module  : axi4_lite_byte_port_pkg
// Brief   : Register offsets, STATUS bit positions and decode helper for the
//           AXI4-Lite byte output port.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package axi4_lite_byte_port_pkg;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_SCRATCH = 2'd2;

  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;

  // The window is 16 bytes, so only address bits [31:4] take part in the match.
  function automatic logic tag_hit(input logic [27:0] addr_tag,
                                   input logic [27:0] base_tag);
    return addr_tag == base_tag;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_lite_byte_port_fifo.sv
// ============================================================================
// Module  : byte_fifo
// Brief   : Byte FIFO; pointers carry one extra wrap bit to separate full/empty.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/axi4_lite_byte_port.sv
// ============================================================================
// Module  : axi4_lite_byte_port
// Brief   : AXI4-Lite responder with TXDATA/STATUS/SCRATCH registers feeding a
//           valid/ready byte stream through a small FIFO.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module axi4_lite_byte_port
  import axi4_lite_byte_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic [7:0]  out_byte,
  output logic        out_byte_valid,
  input  logic        out_byte_ready
);

  localparam logic [27:0] BASE_TAG = BASE_ADDR[31:4];

  logic        aw_held_q, aw_held_d;
  logic [31:0] awaddr_q,  awaddr_d;
  logic        w_held_q,  w_held_d;
  logic [31:0] wdata_q,   wdata_d;
  logic [3:0]  wstrb_q,   wstrb_d;
  logic        bvalid_q,  bvalid_d;
  logic        rvalid_q,  rvalid_d;
  logic [31:0] rdata_q,   rdata_d;
  logic        ovf_q,     ovf_d;
  logic [31:0] scratch_q, scratch_d;

  logic        aw_hs, w_hs, ar_hs, commit;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic        wr_hit, rd_hit;
  logic        wr_tx, ovf_clr, pop;
  logic        fifo_full, fifo_empty, fifo_push;
  logic [31:0] status_word, rd_word;
  logic        unused_bits;

  assign unused_bits = ^{mem_axi_awprot, mem_axi_arprot,
                         mem_axi_araddr[1:0], wr_addr[1:0]};

  assign mem_axi_awready = !aw_held_q && !bvalid_q;
  assign mem_axi_wready  = !w_held_q && !bvalid_q;
  assign mem_axi_arready = !rvalid_q;
  assign mem_axi_bvalid  = bvalid_q;
  assign mem_axi_rvalid  = rvalid_q;
  assign mem_axi_rdata   = rdata_q;

  assign aw_hs  = mem_axi_awvalid && mem_axi_awready;
  assign w_hs   = mem_axi_wvalid && mem_axi_wready;
  assign ar_hs  = mem_axi_arvalid && mem_axi_arready;
  assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

  // Held values take priority; otherwise the channel is handshaking this cycle.
  assign wr_addr = aw_held_q ? awaddr_q : mem_axi_awaddr;
  assign wr_data = w_held_q  ? wdata_q  : mem_axi_wdata;
  assign wr_strb = w_held_q  ? wstrb_q  : mem_axi_wstrb;

  assign wr_hit  = tag_hit(wr_addr[31:4], BASE_TAG);
  assign rd_hit  = tag_hit(mem_axi_araddr[31:4], BASE_TAG);

  assign pop       = out_byte_valid && out_byte_ready;
  assign wr_tx     = commit && wr_hit && (wr_addr[3:2] == OFF_TXDATA) && wr_strb[0];
  assign ovf_clr   = commit && wr_hit && (wr_addr[3:2] == OFF_STATUS) &&
                     wr_strb[0] && wr_data[ST_OVF];
  assign fifo_push = wr_tx && (!fifo_full || pop);

  always_comb begin
    status_word           = '0;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_OVF]   = ovf_q;
    rd_word               = '0;
    if (rd_hit) begin
      case (mem_axi_araddr[3:2])
        OFF_STATUS:  rd_word = status_word;
        OFF_SCRATCH: rd_word = scratch_q;
        default:     rd_word = '0;
      endcase
    end
  end

  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    ovf_d     = ovf_q;
    scratch_d = scratch_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = mem_axi_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = mem_axi_wdata;
      wstrb_d  = mem_axi_wstrb;
    end
    if (bvalid_q && mem_axi_bready) bvalid_d = 1'b0;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (wr_hit && (wr_addr[3:2] == OFF_SCRATCH)) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) scratch_d[8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end

    // A fresh overflow beats a concurrent clear.
    if (ovf_clr) ovf_d = 1'b0;
    if (wr_tx && fifo_full && !pop) ovf_d = 1'b1;

    if (rvalid_q && mem_axi_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      ovf_q     <= 1'b0;
      scratch_q <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      ovf_q     <= ovf_d;
      scratch_q <= scratch_d;
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (fifo_push),
    .din_i   (wr_data[7:0]),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (out_byte)
  );

  assign out_byte_valid = !fifo_empty;

endmodule

`default_nettype wire
